// File: rtl/fpu_dispatch.sv
// fpu_dispatch: single-outstanding issue stage in front of the FPU.
// Request in, one-hot opcode pulse out, response back with watchdog.
//
// Ports
//   sys_clk, rstn      clock, async active-low reset
//   req_*              request handshake from the core (op, x1, x2, tag)
//   fpu_opcode         one-hot opcode, non-zero for exactly one cycle
//   fpu_x1, fpu_x2     registered operands, held until the next request
//   fpu_y, fpu_ovf     FPU result, qualified by fpu_out_valid
//   rsp_*              response handshake back to the core
//   busy               high whenever a request is in flight
module fpu_dispatch #(
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 4
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [7:0]       fpu_opcode,
    output logic [31:0]      fpu_x1,
    output logic [31:0]      fpu_x2,
    input  logic [31:0]      fpu_y,
    input  logic             fpu_ovf,
    input  logic             fpu_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_y,
    output logic             rsp_ovf,
    output logic             rsp_timeout,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [31:0]      x1_q, x1_d;
    logic [31:0]      x2_q, x2_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_y_q, rsp_y_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_to_q, rsp_to_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        // The opcode is a pulse: it falls back to zero unless
        // a request is being accepted this cycle.
        opcode_d    = 8'h00;
        x1_d        = x1_q;
        x2_d        = x2_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_to_d    = rsp_to_q;
        rsp_tag_d   = rsp_tag_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d  = S_ISSUE;
                    opcode_d = 8'h01 << req_op;
                    x1_d     = req_x1;
                    x2_d     = req_x2;
                    tag_d    = req_tag;
                end
            end

            S_ISSUE: begin
                // A result cannot belong to an op issued this same
                // cycle, so fpu_out_valid is not looked at here.
                state_d = S_WAIT;
                cnt_d   = '0;
            end

            S_WAIT: begin
                if (fpu_out_valid) begin
                    // A real answer beats the watchdog on a tie.
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_y_d     = fpu_y;
                    rsp_ovf_d   = fpu_ovf;
                    rsp_to_d    = 1'b0;
                    rsp_tag_d   = tag_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_y_d     = 32'h0;
                    rsp_ovf_d   = 1'b0;
                    rsp_to_d    = 1'b1;
                    rsp_tag_d   = tag_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opcode_q    <= 8'h00;
            x1_q        <= 32'h0;
            x2_q        <= 32'h0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= 32'h0;
            rsp_ovf_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_to_q    <= rsp_to_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    // Ready is masked by rstn so every output reads zero while
    // reset is held, and rises as soon as reset is released.
    assign req_ready   = rstn && (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign fpu_opcode  = opcode_q;
    assign fpu_x1      = x1_q;
    assign fpu_x2      = x2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_y       = rsp_y_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_timeout = rsp_to_q;
    assign rsp_tag     = rsp_tag_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: randomized self-checking bench for fpu_dispatch.
// Responses are predicted from the request/answer timing rules.
module tb_fpu_dispatch;

    localparam int TIMEOUT = 64;
    localparam int TAG_W   = 4;

    logic             sys_clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = '0;
    logic [31:0]      req_x1 = '0;
    logic [31:0]      req_x2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [7:0]       fpu_opcode;
    logic [31:0]      fpu_x1;
    logic [31:0]      fpu_x2;
    logic [31:0]      fpu_y = '0;
    logic             fpu_ovf = 1'b0;
    logic             fpu_out_valid = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_y;
    logic             rsp_ovf;
    logic             rsp_timeout;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    fpu_dispatch #(
        .TIMEOUT(TIMEOUT),
        .TAG_W  (TAG_W)
    ) dut (
        .sys_clk      (sys_clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_x1       (req_x1),
        .req_x2       (req_x2),
        .req_tag      (req_tag),
        .fpu_opcode   (fpu_opcode),
        .fpu_x1       (fpu_x1),
        .fpu_x2       (fpu_x2),
        .fpu_y        (fpu_y),
        .fpu_ovf      (fpu_ovf),
        .fpu_out_valid(fpu_out_valid),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_ovf      (rsp_ovf),
        .rsp_timeout  (rsp_timeout),
        .rsp_tag      (rsp_tag),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic             got;
        logic             rdy0;
        int               opc_cycles;
        int               opc_first;
        logic [7:0]       opc_val;
        int               lat;
        logic [31:0]      y;
        logic             ovf;
        logic             to;
        logic [TAG_W-1:0] tag;
        int               x_bad;
        int               rdy_bad;
        int               stab_bad;
        int               end_bad;
    } obs_t;

    // Reference: the FPU answer counts only if it lands in one of
    // the TIMEOUT cycles after the opcode cycle; d is the answer's
    // distance from the opcode cycle (negative = never answers).
    function automatic void ref_rsp(
        input  int          d,
        input  logic [31:0] y,
        input  logic        ovf,
        output logic [31:0] ey,
        output logic        eovf,
        output logic        eto,
        output int          elat
    );
        if (d >= 1 && d <= TIMEOUT) begin
            ey = y; eovf = ovf; eto = 1'b0; elat = d + 1;
        end else begin
            ey = 32'h0; eovf = 1'b0; eto = 1'b1; elat = TIMEOUT + 1;
        end
    endfunction

    // Drives one request, plays the FPU, then holds rsp_ready low
    // for `hold` cycles before completing the response handshake.
    task automatic do_txn(
        input  logic [2:0]       op,
        input  logic [31:0]      x1,
        input  logic [31:0]      x2,
        input  logic [TAG_W-1:0] tag,
        input  int               d,
        input  logic [31:0]      y,
        input  logic             ovf,
        input  int               hold,
        output obs_t             o
    );
        int t;
        o = '{got: 1'b0, rdy0: 1'b0, opc_cycles: 0, opc_first: -1,
              opc_val: 8'h00, lat: -1, y: 32'h0, ovf: 1'b0, to: 1'b0,
              tag: '0, x_bad: 0, rdy_bad: 0, stab_bad: 0, end_bad: 0};
        @(posedge sys_clk); #1;
        req_valid = 1'b1; req_op = op; req_x1 = x1; req_x2 = x2;
        req_tag = tag; rsp_ready = 1'b0;
        fpu_out_valid = 1'b1; fpu_y = $urandom; fpu_ovf = 1'b1;
        @(negedge sys_clk);
        o.rdy0 = req_ready;
        t = 0;
        while (!o.got && t < TIMEOUT + 20) begin
            @(posedge sys_clk); #1;
            t++;
            req_valid = 1'b0;
            req_x1 = $urandom; req_x2 = $urandom; req_tag = 4'($urandom);
            fpu_out_valid = (t - 1 == d);
            fpu_y = (t - 1 == d) ? y : $urandom;
            fpu_ovf = (t - 1 == d) ? ovf : 1'($urandom);
            @(negedge sys_clk);
            if (fpu_opcode != 8'h00) begin
                o.opc_cycles++;
                o.opc_val = fpu_opcode;
                if (o.opc_first < 0) o.opc_first = t;
            end
            if (fpu_x1 !== x1 || fpu_x2 !== x2) o.x_bad++;
            if (req_ready !== 1'b0) o.rdy_bad++;
            if (rsp_valid === 1'b1) begin
                o.got = 1'b1; o.lat = t - 1;
                o.y = rsp_y; o.ovf = rsp_ovf;
                o.to = rsp_timeout; o.tag = rsp_tag;
            end
        end
        if (o.got) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge sys_clk); #1;
                rsp_ready = 1'b0;
                req_valid = 1'b1; req_op = 3'($urandom);
                req_x1 = $urandom; req_tag = 4'($urandom);
                fpu_out_valid = (k == hold / 2);
                fpu_y = ~o.y; fpu_ovf = ~o.ovf;
                @(negedge sys_clk);
                if (rsp_valid !== 1'b1 || rsp_y !== o.y ||
                    rsp_ovf !== o.ovf || rsp_timeout !== o.to ||
                    rsp_tag !== o.tag || req_ready !== 1'b0 ||
                    fpu_opcode !== 8'h00)
                    o.stab_bad++;
            end
            @(posedge sys_clk); #1;
            req_valid = 1'b0; fpu_out_valid = 1'b0; rsp_ready = 1'b1;
            @(negedge sys_clk);
            if (rsp_valid !== 1'b1) o.end_bad++;
            @(posedge sys_clk); #1;
            rsp_ready = 1'b0;
            @(negedge sys_clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
                o.end_bad++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b0 || fpu_opcode !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b busy=%b opc=%h want 0 0 00",
                     req_ready, busy, fpu_opcode);
        end
        checks++;
        if ({fpu_x1, fpu_x2, rsp_y} !== 96'h0 || rsp_valid !== 1'b0 ||
            rsp_ovf !== 1'b0 || rsp_timeout !== 1'b0 || rsp_tag !== '0) begin
            errors++;
            $display("FAIL reset_data: x1=%h x2=%h y=%h v=%b want all 0",
                     fpu_x1, fpu_x2, rsp_y, rsp_valid);
        end
        @(negedge sys_clk);
        rstn = 1'b1;
        @(posedge sys_clk); #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b want 1 0",
                     req_ready, busy);
        end
    endtask

    task automatic test_single();
        obs_t o;
        logic [31:0] ey; logic eovf, eto; int elat;
        ref_rsp(6, 32'h4040_0000, 1'b0, ey, eovf, eto, elat);
        do_txn(3'd7, 32'h3f80_0000, 32'h4000_0000, 4'hA, 6,
               32'h4040_0000, 1'b0, 0, o);
        checks++;
        if (o.rdy0 !== 1'b1 || o.got !== 1'b1) begin
            errors++;
            $display("FAIL single_hs: ready=%b got=%b want 1 1", o.rdy0, o.got);
        end
        checks++;
        if (o.opc_val !== 8'h80 || o.opc_cycles != 1 || o.opc_first != 1) begin
            errors++;
            $display("FAIL single_opcode: opc=%h n=%0d at=%0d want 80 1 1",
                     o.opc_val, o.opc_cycles, o.opc_first);
        end
        checks++;
        if (o.x_bad != 0 || o.rdy_bad != 0) begin
            errors++;
            $display("FAIL single_hold: xbad=%0d rdybad=%0d want 0 0",
                     o.x_bad, o.rdy_bad);
        end
        checks++;
        if (o.y !== ey || o.ovf !== eovf || o.to !== eto || o.tag !== 4'hA) begin
            errors++;
            $display("FAIL single_rsp: y=%h ovf=%b to=%b tag=%h want %h %b %b a",
                     o.y, o.ovf, o.to, o.tag, ey, eovf, eto);
        end
        checks++;
        if (o.lat != elat || o.end_bad != 0) begin
            errors++;
            $display("FAIL single_lat: lat=%0d endbad=%0d want %0d 0",
                     o.lat, o.end_bad, elat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ys[7];
        int acc_t[$];
        logic [7:0] opcs[$];
        logic [TAG_W-1:0] rtags[$];
        logic [31:0] rys[$];
        int t = 0, idx = 0, pend = -1, dbl = 0, busy_acc = 0;
        logic [7:0] prev = 8'h00;
        logic acc;
        foreach (ys[i]) ys[i] = $urandom;
        @(posedge sys_clk); #1;
        rsp_ready = 1'b1; fpu_out_valid = 1'b0;
        req_valid = 1'b1; req_op = 3'd0; req_tag = '0;
        req_x1 = $urandom; req_x2 = $urandom;
        while (rys.size() < 7 && t < 100) begin
            @(negedge sys_clk);
            acc = req_valid && req_ready;
            if (acc) acc_t.push_back(t);
            if (req_ready && (fpu_opcode != 8'h00 || rsp_valid)) busy_acc++;
            if (fpu_opcode != 8'h00) begin
                opcs.push_back(fpu_opcode);
                pend = t + 1;
                if (prev != 8'h00) dbl++;
            end
            prev = fpu_opcode;
            if (rsp_valid === 1'b1) begin
                rtags.push_back(rsp_tag);
                rys.push_back(rsp_y);
            end
            @(posedge sys_clk); #1;
            t++;
            if (acc) begin
                idx++;
                if (idx < 7) begin
                    req_op = 3'(idx); req_tag = 4'(idx);
                    req_x1 = $urandom; req_x2 = $urandom;
                end else begin
                    req_valid = 1'b0;
                end
            end
            fpu_out_valid = (t == pend);
            fpu_y = (t == pend && opcs.size() <= 7) ?
                    ys[opcs.size() - 1] : $urandom;
        end
        rsp_ready = 1'b0;
        checks++;
        if (acc_t.size() != 7 || opcs.size() != 7 || rys.size() != 7) begin
            errors++;
            $display("FAIL b2b_counts: acc=%0d opc=%0d rsp=%0d want 7 7 7",
                     acc_t.size(), opcs.size(), rys.size());
        end
        checks++;
        if (dbl != 0 || busy_acc != 0) begin
            errors++;
            $display("FAIL b2b_pulse: wide=%0d ready_busy=%0d want 0 0",
                     dbl, busy_acc);
        end
        for (int i = 0; i < 7; i++) begin
            if (i < opcs.size()) begin
                checks++;
                if (opcs[i] !== 8'(2 ** i)) begin
                    errors++;
                    $display("FAIL b2b_opc[%0d]: got %h want %h",
                             i, opcs[i], 8'(2 ** i));
                end
            end
            if (i < rys.size()) begin
                checks++;
                if (rtags[i] !== 4'(i) || rys[i] !== ys[i]) begin
                    errors++;
                    $display("FAIL b2b_rsp[%0d]: tag=%h y=%h want %h %h",
                             i, rtags[i], rys[i], 4'(i), ys[i]);
                end
            end
            if (i > 0 && i < acc_t.size()) begin
                checks++;
                if (acc_t[i] - acc_t[i-1] != 4) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: got %0d want 4",
                             i, acc_t[i] - acc_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        logic [31:0] ey; logic eovf, eto; int elat;
        logic [TAG_W-1:0] tg;
        int ds[3] = '{-1, 0, TIMEOUT + 1};
        foreach (ds[i]) begin
            tg = 4'($urandom);
            ref_rsp(ds[i], 32'hdead_beef, 1'b1, ey, eovf, eto, elat);
            do_txn(3'($urandom), $urandom, $urandom, tg, ds[i],
                   32'hdead_beef, 1'b1, 0, o);
            checks++;
            if (o.got !== 1'b1 || o.lat != elat) begin
                errors++;
                $display("FAIL timeout_lat d=%0d: got=%b lat=%0d want 1 %0d",
                         ds[i], o.got, o.lat, elat);
            end
            checks++;
            if (o.to !== eto || o.y !== ey || o.ovf !== eovf || o.tag !== tg) begin
                errors++;
                $display("FAIL timeout_rsp d=%0d: to=%b y=%h ovf=%b tag=%h want %b %h %b %h",
                         ds[i], o.to, o.y, o.ovf, o.tag, eto, ey, eovf, tg);
            end
        end
    endtask

    task automatic test_tie();
        obs_t o;
        logic [31:0] yv, ey; logic eovf, eto; int elat;
        yv = $urandom;
        ref_rsp(TIMEOUT, yv, 1'b1, ey, eovf, eto, elat);
        do_txn(3'd3, $urandom, $urandom, 4'h5, TIMEOUT, yv, 1'b1, 0, o);
        checks++;
        if (o.to !== eto || o.ovf !== eovf || o.y !== ey || o.lat != elat) begin
            errors++;
            $display("FAIL tie: to=%b ovf=%b y=%h lat=%0d want %b %b %h %0d",
                     o.to, o.ovf, o.y, o.lat, eto, eovf, ey, elat);
        end
    endtask

    task automatic test_hold();
        obs_t o;
        logic [31:0] yv, ey; logic eovf, eto; int elat, d;
        yv = $urandom; d = $urandom_range(1, 5);
        ref_rsp(d, yv, 1'b0, ey, eovf, eto, elat);
        do_txn(3'($urandom), $urandom, $urandom, 4'h9, d, yv, 1'b0, 10, o);
        checks++;
        if (o.stab_bad != 0 || o.end_bad != 0) begin
            errors++;
            $display("FAIL hold: unstable=%0d endbad=%0d want 0 0",
                     o.stab_bad, o.end_bad);
        end
        checks++;
        if (o.y !== ey || o.to !== eto || o.tag !== 4'h9) begin
            errors++;
            $display("FAIL hold_rsp: y=%h to=%b tag=%h want %h %b 9",
                     o.y, o.to, o.tag, ey, eto);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] yv, x1, x2, ey; logic ov, eovf, eto; int elat, d, sel;
        logic [2:0] op; logic [TAG_W-1:0] tg;
        for (int n = 0; n < 14; n++) begin
            sel = $urandom_range(0, 9);
            d = (sel == 0) ? TIMEOUT :
                (sel == 1) ? 0 : $urandom_range(1, 9);
            op = 3'($urandom); tg = 4'($urandom);
            x1 = $urandom; x2 = $urandom; yv = $urandom; ov = 1'($urandom);
            ref_rsp(d, yv, ov, ey, eovf, eto, elat);
            do_txn(op, x1, x2, tg, d, yv, ov, $urandom_range(0, 3), o);
            checks++;
            if (o.opc_val !== 8'(2 ** op) || o.opc_cycles != 1 ||
                o.x_bad != 0 || o.rdy_bad != 0) begin
                errors++;
                $display("FAIL rnd_issue[%0d]: opc=%h n=%0d xbad=%0d rdybad=%0d want %h 1 0 0",
                         n, o.opc_val, o.opc_cycles, o.x_bad, o.rdy_bad,
                         8'(2 ** op));
            end
            checks++;
            if (o.y !== ey || o.ovf !== eovf || o.to !== eto ||
                o.tag !== tg || o.lat != elat) begin
                errors++;
                $display("FAIL rnd_rsp[%0d]: y=%h ovf=%b to=%b tag=%h lat=%0d want %h %b %b %h %0d",
                         n, o.y, o.ovf, o.to, o.tag, o.lat,
                         ey, eovf, eto, tg, elat);
            end
            checks++;
            if (o.stab_bad != 0 || o.end_bad != 0) begin
                errors++;
                $display("FAIL rnd_hs[%0d]: unstable=%0d endbad=%0d want 0 0",
                         n, o.stab_bad, o.end_bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int late = 0;
        @(posedge sys_clk); #1;
        req_valid = 1'b1; req_op = 3'd2; req_tag = 4'hC;
        req_x1 = $urandom | 32'h1; req_x2 = $urandom | 32'h1;
        fpu_out_valid = 1'b0;
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge sys_clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b0 || fpu_opcode !== 8'h00 ||
            fpu_x1 !== 32'h0 || fpu_x2 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_ctl: busy=%b ready=%b opc=%h x1=%h x2=%h want 0",
                     busy, req_ready, fpu_opcode, fpu_x1, fpu_x2);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_y !== 32'h0 || rsp_ovf !== 1'b0 ||
            rsp_timeout !== 1'b0 || rsp_tag !== '0) begin
            errors++;
            $display("FAIL midrst_rsp: v=%b y=%h ovf=%b to=%b tag=%h want 0",
                     rsp_valid, rsp_y, rsp_ovf, rsp_timeout, rsp_tag);
        end
        @(negedge sys_clk);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge sys_clk); #1;
            fpu_out_valid = (k == 1);
            @(negedge sys_clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) late++;
        end
        fpu_out_valid = 1'b0;
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL midrst_drop: stray cycles=%0d want 0", late);
        end
        do_txn(3'd7, 32'h3f80_0000, 32'h4000_0000, 4'hA, 6,
               32'h4040_0000, 1'b0, 0, o);
        checks++;
        if (o.opc_val !== 8'h80 || o.opc_cycles != 1 || o.y !== 32'h4040_0000 ||
            o.to !== 1'b0 || o.tag !== 4'hA || o.lat != 7) begin
            errors++;
            $display("FAIL midrst_after: opc=%h n=%0d y=%h to=%b tag=%h lat=%0d want 80 1 40400000 0 a 7",
                     o.opc_val, o.opc_cycles, o.y, o.to, o.tag, o.lat);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_tie();
        test_hold();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
